pc_trace_monitor: RTL

Simulation-and-FPGA harness block sitting directly downstream of the `system` composite. It consumes the retired-PC stream (`pc`, `pc_enable`) and buffers each PC with a sequence number in a FIFO. The buffered entries drain over a valid/ready port to the host or testbench. It also detects test termination: either a self-loop (`j .`) or a watchdog timeout. On termination it stops capture, drains, and raises `out_done`.

---
 rtl/pc_trace_pkg.sv | 25 ++
 rtl/pc_trace_fifo.sv | 57 +++++
 rtl/pc_trace_monitor.sv | 155 +++++++++++++++
 3 files changed

// File: rtl/pc_trace_pkg.sv
// pc_trace_pkg
//   Shared types for the retired-PC trace monitor: halt causes, monitor
//   states and the packed FIFO entry carrying a sequence number and PC.
package pc_trace_pkg;

  localparam int SEQ_W = 16;

  typedef enum logic [1:0] {
    NONE      = 2'd0,
    SELF_LOOP = 2'd1,
    WATCHDOG  = 2'd2
  } halt_cause_t;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    DRAIN = 2'd1,
    DONE  = 2'd2
  } trace_state_t;

  typedef struct packed {
    logic [SEQ_W-1:0] seq;
    logic [31:0]      pc;
  } trace_entry_t;

endpackage

// File: rtl/pc_trace_fifo.sv
// pc_trace_fifo
//   Synchronous FIFO of trace entries, Depth entries (power of two).
//   Full/empty come from read/write pointers carrying one extra wrap bit.
// Ports:
//   CLK    - clock, all updates on posedge
//   RESET  - synchronous active-low reset, empties the FIFO
//   push   - write din (accepted when not full, or when full with a pop)
//   pop    - discard the head entry (ignored when empty)
//   din    - entry to write
//   full   - no free slot
//   empty  - no stored entry
//   head   - oldest entry, read straight from storage
module pc_trace_fifo
  import pc_trace_pkg::*;
#(
  parameter int Depth = 16
) (
  input  logic         CLK,
  input  logic         RESET,
  input  logic         push,
  input  logic         pop,
  input  trace_entry_t din,
  output logic         full,
  output logic         empty,
  output trace_entry_t head
);

  localparam int AW = $clog2(Depth);

  trace_entry_t   mem [Depth];
  logic [AW:0]    wr_ptr;
  logic [AW:0]    rd_ptr;
  logic           wr_en;
  logic           rd_en;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  // A full FIFO still takes a write when the head leaves on the same edge.
  assign wr_en = push && (!full || pop);
  assign rd_en = pop && !empty;
  assign head  = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge CLK) begin
    if (!RESET) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (rd_en) rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge CLK) begin
    if (wr_en) mem[wr_ptr[AW-1:0]] <= din;
  end

endmodule

// File: rtl/pc_trace_monitor.sv
// pc_trace_monitor
//   Captures the retired-PC stream into a FIFO tagged with a 16-bit sequence
//   number, drains it over valid/ready, and detects test termination by a
//   self-loop (LoopLimit identical consecutive PCs) or, when the macro
//   PC_TRACE_WATCHDOG_EN is defined, by WatchdogCycles idle RUN cycles.
//   After a halt capture stops, the FIFO drains and out_done rises.
// Ports:
//   CLK, RESET        - clock; synchronous active-low reset
//   in_pc, in_pc_enable - retired PC and its strobe
//   out_trace_valid, in_trace_ready - head handshake
//   out_trace_pc, out_trace_seq     - head entry fields
//   out_overflow      - sticky, an entry was dropped
//   out_halt_cause    - 0 none, 1 self-loop, 2 watchdog
//   out_halt_pc       - PC associated with the halt
//   out_done          - halted and drained
module pc_trace_monitor
  import pc_trace_pkg::*;
#(
  parameter int Depth          = 16,
  parameter int LoopLimit      = 8,
  parameter int WatchdogCycles = 65536
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic [31:0] in_pc,
  input  logic        in_pc_enable,
  output logic        out_trace_valid,
  input  logic        in_trace_ready,
  output logic [31:0] out_trace_pc,
  output logic [15:0] out_trace_seq,
  output logic        out_overflow,
  output logic [1:0]  out_halt_cause,
  output logic [31:0] out_halt_pc,
  output logic        out_done
);

  localparam logic [7:0] LOOP_LIM = 8'(LoopLimit);

  trace_state_t     state;
  halt_cause_t      cause;
  logic [31:0]      halt_pc;
  logic [31:0]      last_pc;
  logic [SEQ_W-1:0] seq;
  logic [7:0]       rep_cnt;
  logic [7:0]       rep_next;
  logic             overflow;
  logic             done;

  logic             fifo_full;
  logic             fifo_empty;
  trace_entry_t     fifo_head;
  trace_entry_t     push_entry;
  logic             capture;
  logic             pop;
  logic             push;
  logic             loop_hit;
  logic             wd_hit;

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  assign capture    = in_pc_enable && (state == RUN);
  assign pop        = !fifo_empty && in_trace_ready;
  assign push       = capture && (!fifo_full || pop);
  assign push_entry = '{seq: seq, pc: in_pc};
  // last_pc and rep_cnt both clear on reset, so the first enable lands on 1
  // whether or not its PC happens to be zero.
  assign rep_next   = (in_pc == last_pc) ? sat_inc(rep_cnt) : 8'd1;
  assign loop_hit   = capture && (rep_next >= LOOP_LIM);

`ifdef PC_TRACE_WATCHDOG_EN
  localparam int WD_W = $clog2(WatchdogCycles + 1);
  localparam logic [WD_W-1:0] WD_LIM = WD_W'(WatchdogCycles);

  logic [WD_W-1:0] wd_cnt;

  // Fires on the edge at which the idle count would reach the limit.
  assign wd_hit = (state == RUN) && !in_pc_enable && ((wd_cnt + 1'b1) == WD_LIM);

  always_ff @(posedge CLK) begin
    if (!RESET) begin
      wd_cnt <= '0;
    end else if (state == RUN) begin
      wd_cnt <= in_pc_enable ? '0 : wd_cnt + 1'b1;
    end
  end
`else
  // No watchdog in this build; the comparison is constant false.
  assign wd_hit = (WatchdogCycles < 0);
`endif

  pc_trace_fifo #(.Depth(Depth)) u_fifo (
    .CLK   (CLK),
    .RESET (RESET),
    .push  (push),
    .pop   (pop),
    .din   (push_entry),
    .full  (fifo_full),
    .empty (fifo_empty),
    .head  (fifo_head)
  );

  always_ff @(posedge CLK) begin
    if (!RESET) begin
      state    <= RUN;
      cause    <= NONE;
      halt_pc  <= '0;
      last_pc  <= '0;
      seq      <= '0;
      rep_cnt  <= '0;
      overflow <= 1'b0;
      done     <= 1'b0;
    end else begin
      case (state)
        RUN: begin
          if (capture) begin
            seq     <= seq + 1'b1;
            last_pc <= in_pc;
            rep_cnt <= rep_next;
            if (fifo_full && !pop) overflow <= 1'b1;
          end
          // Self-loop has priority over the watchdog.
          if (loop_hit) begin
            cause   <= SELF_LOOP;
            halt_pc <= in_pc;
            state   <= DRAIN;
          end else if (wd_hit) begin
            cause   <= WATCHDOG;
            halt_pc <= last_pc;
            state   <= DRAIN;
          end
        end
        DRAIN: begin
          if (fifo_empty) begin
            state <= DONE;
            done  <= 1'b1;
          end
        end
        DONE: ;
        default: state <= RUN;
      endcase
    end
  end

  // Head fields read as zero while empty so reset leaves all outputs at 0.
  assign out_trace_valid = !fifo_empty;
  assign out_trace_pc    = fifo_empty ? 32'd0 : fifo_head.pc;
  assign out_trace_seq   = fifo_empty ? 16'd0 : fifo_head.seq;
  assign out_overflow    = overflow;
  assign out_halt_cause  = cause;
  assign out_halt_pc     = halt_pc;
  assign out_done        = done;

endmodule
